// File: rtl/mat4_vec4_sched_pkg.sv
// Shared widths, FSM encoding and lane helper
// for the 4x4 matrix by 4-vector sequencer.
package mat4_vec4_sched_pkg;

  localparam int FP_W  = 32;
  localparam int VEC_N = 4;
  localparam int BEATS = 16;
  localparam int VEC_W = FP_W * VEC_N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [FP_W-1:0] lane_sel(
    input logic [VEC_W-1:0] v,
    input logic [1:0]       k
  );
    return v[{k, 5'd0} +: FP_W];
  endfunction

endpackage

// File: rtl/mat4_vec4_sched_tags.sv
// Row-tag delay line that shadows the dot unit latency.
// Each stage holds {valid, row}; frozen while en_i is low.
module tag_delay_line #(
  parameter int DEPTH = 14,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mat4_vec4_sched.sv
// Streams 16 matrix/vector element pairs into a shared
// pipelined dot unit and gathers the four row sums.
module mat4_vec4_sched
  import mat4_vec4_sched_pkg::*;
#(
  parameter int DOT_LATENCY = 14
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [VEC_W-1:0] vec_in_i,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [VEC_W-1:0] out_vec_o,
  output logic [3:0]       mat_addr_o,
  output logic             mat_rd_o,
  input  logic [FP_W-1:0]  mat_rdata_i,
  output logic [FP_W-1:0]  dot_v1_o,
  output logic [FP_W-1:0]  dot_v2_o,
  output logic             dot_clk_en_o,
  output logic             dot_aclr_o,
  input  logic [FP_W-1:0]  dot_result_i
);

  state_e                     state_q, state_d;
  logic [3:0]                 b_q, b_d;
  logic [VEC_W-1:0]           vec_q, vec_d;
  logic                       rd_q;
  logic [3:0]                 ab_q;
  logic [VEC_N-1:0][FP_W-1:0] out_q;
  logic [2:0]                 tag_in;
  logic [2:0]                 tag_out;
  logic                       run;
  logic                       accept;
  logic                       live;

  assign run    = resetn_i && !hold_i;
  assign accept = run && (state_q == S_IDLE) && start_i;
  assign live   = resetn_i && rd_q;

  // Last beat of a row group tags that row into the delay line
  assign tag_in = {rd_q && (ab_q[1:0] == 2'd3), ab_q[3:2]};

  tag_delay_line #(
    .DEPTH (DOT_LATENCY),
    .W     (3)
  ) u_tags (
    .clk_i  (clock_i),
    .clr_ni (resetn_i),
    .en_i   (!hold_i),
    .d_i    (tag_in),
    .q_o    (tag_out)
  );

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    vec_d   = vec_q;
    if (run) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_ISSUE;
            b_d     = '0;
            vec_d   = vec_in_i;
          end
        end
        S_ISSUE: begin
          b_d = b_q + 4'd1;
          if (b_q == 4'(BEATS - 1)) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tag_out[2] && (tag_out[1:0] == 2'd3)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = resetn_i && (state_q != S_IDLE);
  assign done_o       = run && (state_q == S_DONE);
  assign mat_rd_o     = run && (state_q == S_ISSUE);
  assign mat_addr_o   = resetn_i ? b_q : '0;
  assign dot_v1_o     = live ? mat_rdata_i : '0;
  assign dot_v2_o     = live ? lane_sel(vec_q, ab_q[1:0]) : '0;
  assign dot_clk_en_o = !hold_i;
  assign dot_aclr_o   = !resetn_i || accept;
  assign out_vec_o    = out_q;

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      vec_q   <= '0;
      rd_q    <= 1'b0;
      ab_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      if (!hold_i) begin
        rd_q <= mat_rd_o;
        ab_q <= b_q;
        if (tag_out[2]) begin
          out_q[tag_out[1:0]] <= dot_result_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat4_vec4_sched.sv
// Bench for mat4_vec4_sched: matrix memory and dot unit
// emulated with real arithmetic, results checked per scenario.
module tb_mat4_vec4_sched;

  localparam int L = 14;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [127:0] vec_in = '0;
  logic         busy, done, mat_rd, dot_clk_en, dot_aclr;
  logic [127:0] out_vec;
  logic [3:0]   mat_addr;
  logic [31:0]  mat_rdata, dot_v1, dot_v2, dot_result;

  logic [31:0]  mem  [16];
  logic [31:0]  pipe [L];
  real          win  [3];
  bit           hold_pat [64];
  bit           xstart   [64];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  mat4_vec4_sched #(.DOT_LATENCY(L)) dut (
    .clock_i      (clk),
    .resetn_i     (resetn),
    .start_i      (start),
    .vec_in_i     (vec_in),
    .hold_i       (hold),
    .busy_o       (busy),
    .done_o       (done),
    .out_vec_o    (out_vec),
    .mat_addr_o   (mat_addr),
    .mat_rd_o     (mat_rd),
    .mat_rdata_i  (mat_rdata),
    .dot_v1_o     (dot_v1),
    .dot_v2_o     (dot_v2),
    .dot_clk_en_o (dot_clk_en),
    .dot_aclr_o   (dot_aclr),
    .dot_result_i (dot_result)
  );

  function automatic real b2r(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2b(input real r);
    logic   s;
    int     e;
    real    a;
    longint m;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rint();
    int k;
    k = int'($urandom_range(16)) - 8;
    return r2b(real'(k));
  endfunction

  // 1-cycle read memory; output register holds when not read
  always @(posedge clk) begin
    if (mat_rd) mat_rdata <= mem[mat_addr];
  end

  // Dot unit: sum of the last four products, L enabled cycles late
  always @(posedge clk) begin
    if (dot_aclr) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
      for (int i = 0; i < 3; i++) win[i] <= 0.0;
    end else if (dot_clk_en) begin
      pipe[0] <= r2b(win[0] + win[1] + win[2] + b2r(dot_v1) * b2r(dot_v2));
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      win[0] <= b2r(dot_v1) * b2r(dot_v2);
      win[1] <= win[0];
      win[2] <= win[1];
    end
  end

  assign dot_result = pipe[L-1];

  function automatic logic [127:0] ref_prod(input logic [127:0] v);
    logic [127:0] o;
    real          s;
    for (int r = 0; r < 4; r++) begin
      s = 0.0;
      for (int c = 0; c < 4; c++) s += b2r(mem[4*r+c]) * b2r(v[32*c +: 32]);
      o[32*r +: 32] = r2b(s);
    end
    return o;
  endfunction

  // Done lands after 17+L unheld cycles past the start, on an unheld cycle
  function automatic int ref_done();
    int n;
    n = 0;
    for (int t = 1; t < 64; t++) begin
      if (!hold_pat[t]) begin
        if (n == 17 + L) return t;
        n++;
      end
    end
    return -2;
  endfunction

  function automatic void clear_pats();
    for (int t = 0; t < 64; t++) begin
      hold_pat[t] = 1'b0;
      xstart[t]   = 1'b0;
    end
  endfunction

  function automatic void load_diag(input logic [31:0] d, input bit perm);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int r = 0; r < 4; r++) mem[4*r + (perm ? 3 - r : r)] = d;
  endfunction

  task automatic run_op(input logic [127:0] v, output int done_at,
                        output logic [127:0] res, output int nrd,
                        output int addr_bad, output int busy_bad);
    bit seen;
    seen = 1'b0;
    done_at = -1; res = '0; nrd = 0; addr_bad = 0; busy_bad = 0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(posedge clk); #1;
      start  = (t == 0) || xstart[t];
      vec_in = (t == 0) ? v : {$urandom, $urandom, $urandom, $urandom};
      hold   = hold_pat[t];
      @(negedge clk);
      if (busy !== (t >= 1)) busy_bad++;
      if (mat_rd === 1'b1) begin
        if (mat_addr !== nrd[3:0]) addr_bad++;
        nrd++;
      end
      if (done === 1'b1) begin
        done_at = t;
        res = out_vec;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dot_aclr !== 1'b1) begin errors++; $display("FAIL rst_aclr got %b want 1", dot_aclr); end
    checks++;
    if ({busy, done, mat_rd} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b want 000", {busy, done, mat_rd}); end
    checks++;
    if (mat_addr !== 4'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mat_addr); end
    checks++;
    if (out_vec !== 128'h0) begin errors++; $display("FAIL rst_out got %h want 0", out_vec); end
    checks++;
    if ({dot_v1, dot_v2} !== 64'h0) begin errors++; $display("FAIL rst_ops got %h want 0", {dot_v1, dot_v2}); end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_identity();
    int d, n, ab, bb;
    logic [127:0] r;
    clear_pats();
    load_diag(32'h3F800000, 1'b0);
    run_op(128'h40800000_40400000_40000000_3F800000, d, r, n, ab, bb);
    checks++;
    if (d !== 32) begin errors++; $display("FAIL ident_done got %0d want 32", d); end
    checks++;
    if (r !== 128'h40800000_40400000_40000000_3F800000) begin errors++; $display("FAIL ident_out got %h", r); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL ident_busy got %0d bad cycles want 0", bb); end
  endtask

  task automatic test_scaled();
    int d, n, ab, bb;
    logic [127:0] r;
    clear_pats();
    load_diag(32'h40000000, 1'b0);
    run_op(128'h40800000_40400000_40000000_3F800000, d, r, n, ab, bb);
    checks++;
    if (r !== 128'h41000000_40C00000_40800000_40000000) begin errors++; $display("FAIL scaled_out got %h", r); end
    checks++;
    if (n !== 16 || ab !== 0) begin errors++; $display("FAIL scaled_addr got %0d reads %0d bad want 16 0", n, ab); end
  endtask

  task automatic test_hold();
    int d, n, ab, bb;
    logic [127:0] r;
    clear_pats();
    hold_pat[6] = 1'b1; hold_pat[7] = 1'b1; hold_pat[8] = 1'b1;
    hold_pat[25] = 1'b1; hold_pat[26] = 1'b1;
    load_diag(32'h3F800000, 1'b0);
    run_op(128'h40800000_40400000_40000000_3F800000, d, r, n, ab, bb);
    checks++;
    if (d !== 37) begin errors++; $display("FAIL hold_done got %0d want 37", d); end
    checks++;
    if (r !== 128'h40800000_40400000_40000000_3F800000) begin errors++; $display("FAIL hold_out got %h", r); end
    checks++;
    if (n !== 16 || ab !== 0) begin errors++; $display("FAIL hold_reads got %0d reads %0d bad want 16 0", n, ab); end
    clear_pats();
  endtask

  task automatic test_back_to_back();
    int d, n, ab, bb;
    logic [127:0] r, v;
    clear_pats();
    xstart[5]  = 1'b1;
    xstart[20] = 1'b1;
    xstart[32] = 1'b1;
    load_diag(32'h40000000, 1'b0);
    run_op(128'h40800000_40400000_40000000_3F800000, d, r, n, ab, bb);
    checks++;
    if (d !== 32 || r !== 128'h41000000_40C00000_40800000_40000000) begin
      errors++; $display("FAIL b2b_first got done %0d out %h", d, r);
    end
    clear_pats();
    for (int i = 0; i < 16; i++) mem[i] = rint();
    v = {rint(), rint(), rint(), rint()};
    run_op(v, d, r, n, ab, bb);
    checks++;
    if (d !== 32) begin errors++; $display("FAIL b2b_done got %0d want 32", d); end
    checks++;
    if (r !== ref_prod(v)) begin errors++; $display("FAIL b2b_out got %h want %h", r, ref_prod(v)); end
  endtask

  task automatic test_reset_mid();
    int d, n, ab, bb;
    logic [127:0] r, v;
    clear_pats();
    load_diag(32'h3F800000, 1'b0);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      start  = (t == 0);
      vec_in = 128'h40800000_40400000_40000000_3F800000;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (dot_aclr !== 1'b1) begin errors++; $display("FAIL mid_aclr got %b want 1", dot_aclr); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mat_rd !== 1'b0) begin errors++; $display("FAIL mid_idle got busy %b rd %b", busy, mat_rd); end
    checks++;
    if (out_vec !== 128'h0) begin errors++; $display("FAIL mid_out got %h want 0", out_vec); end
    for (int i = 0; i < 16; i++) mem[i] = rint();
    v = {rint(), rint(), rint(), rint()};
    run_op(v, d, r, n, ab, bb);
    checks++;
    if (d !== 32 || r !== ref_prod(v)) begin
      errors++; $display("FAIL mid_fresh got done %0d out %h want %h", d, r, ref_prod(v));
    end
  endtask

  task automatic test_permutation();
    int d, n, ab, bb;
    logic [127:0] r;
    clear_pats();
    load_diag(32'h3F800000, 1'b1);
    run_op(128'h40800000_40400000_40000000_3F800000, d, r, n, ab, bb);
    checks++;
    if (r !== 128'h3F800000_40000000_40400000_40800000) begin errors++; $display("FAIL perm_out got %h", r); end
  endtask

  task automatic test_random();
    int d, n, ab, bb;
    logic [127:0] r, v;
    for (int k = 0; k < 6; k++) begin
      clear_pats();
      for (int t = 1; t < 40; t++) hold_pat[t] = ($urandom_range(7) == 0);
      for (int i = 0; i < 16; i++) mem[i] = rint();
      v = {rint(), rint(), rint(), rint()};
      run_op(v, d, r, n, ab, bb);
      checks++;
      if (d !== ref_done()) begin errors++; $display("FAIL rand%0d_done got %0d want %0d", k, d, ref_done()); end
      checks++;
      if (r !== ref_prod(v)) begin errors++; $display("FAIL rand%0d_out got %h want %h", k, r, ref_prod(v)); end
      checks++;
      if (n !== 16 || ab !== 0) begin errors++; $display("FAIL rand%0d_reads got %0d reads %0d bad", k, n, ab); end
    end
    clear_pats();
  endtask

  initial begin
    clear_pats();
    test_reset();
    test_identity();
    test_scaled();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_permutation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat4_vec4_sched.md
# mat4_vec4_sched

Sequencer that computes a 4×4 matrix × 4-vector product (IEEE-754 single) by streaming 16 element pairs, one per cycle, into a single shared pipelined dot-product unit (float multiplier followed by a 4-input accumulate stage). It reads matrix elements from a 1-cycle-latency memory, pairs them with a latched input vector, tracks in-flight rows through the dot unit's latency, and assembles the four row results into an output vector. It sits in the vertex-transform path between the transform-matrix store and the rasterizer front end.

## Interface
- DOT_LATENCY, 14: cycles from the last beat of a 4-beat group entering the dot unit to its sum on dot_result; must be ≥ 1.
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request one product; accepted only in IDLE.
- vec_in  in  128  input vector, lane k = bits [32k+31:32k]; sampled on accepted start.
- hold  in  1  global stall; freezes all state and the dot unit.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse; out_vec valid from this cycle on.
- out_vec  out  128  result, lane r = row r dot vec.
- mat_addr  out  4  element address, row*4+col.
- mat_rd  out  1  read strobe; mat_rdata valid the following cycle.
- mat_rdata  in  32  matrix element.
- dot_v1, dot_v2  out  32 each  operands to dot unit.
- dot_clk_en  out  1  dot unit clock enable = ~hold.
- dot_aclr  out  1  dot unit clear.
- dot_result  in  32  dot unit sum.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 → latch vec_in, pulse dot_aclr for that cycle, beat counter b=0, → ISSUE.
- ISSUE: each unheld cycle drive mat_rd=1, mat_addr=b, b++; after b=15 issued → DRAIN.
- Operand alignment: one-cycle-delayed copy of (mat_rd, b) drives the dot unit: dot_v1=mat_rdata, dot_v2=vec lane (b mod 4). dot_v1/dot_v2 = 0 when no beat is in flight.
- Group tracking: when beat with b mod 4 = 3 enters the dot unit, push row tag r=b/4 with valid into a DOT_LATENCY-deep delay line; at the output, valid tag writes dot_result into out_vec lane r.
- DRAIN: wait until row-3 tag exits → DONE.
- DONE: done=1 for one cycle → IDLE. out_vec holds until next capture.
- hold=1: no state, counter, delay-line or operand register changes; mat_rd=0; dot_clk_en=0; done, if due, is deferred.
- start while not IDLE: ignored, no effect. start with hold=1 in IDLE: not accepted.
- Reset: state IDLE, busy=0, done=0, mat_rd=0, mat_addr=0, out_vec=0, delay line cleared, dot_v1=dot_v2=0, dot_aclr=1 while resetn=0. Reset mid-operation abandons the product; out_vec returns to 0.
- No floating-point arithmetic in this block; operands and results passed bit-exact.

## Timing
- Start accepted at cycle T (unheld): mat_addr=i, mat_rd=1 at T+1+i (i=0..15); beat i at dot unit inputs at T+2+i.
- Row r sum captured at T+5+4r+DOT_LATENCY; visible on out_vec next cycle.
- done at T+18+DOT_LATENCY; next start accepted at T+19+DOT_LATENCY earliest. Each held cycle adds one cycle.
- busy rises T+1, falls after done cycle.

## Structure
- Shared package: FP_W=32, VEC_N=4, BEATS=16, state enum, lane-select helper.
- Sub-module tag_delay_line (params DEPTH, W): shift register of {valid, tag[1:0]} with enable, synchronous active-low clear.

## Test plan
- Identity matrix, vec_in={40800000,40400000,40000000,3F800000}, DOT_LATENCY=14 → done at T+32, out_vec lanes 3F800000,40000000,40400000,40800000.
- Matrix 2·I, same vec → lanes 40000000,40800000,40C00000,41000000; mat_addr sequence 0..15 exactly once.
- hold pulsed 3 cycles at T+6 and 2 cycles during DRAIN → done at T+37, results unchanged, no duplicate mat_rd.
- start reasserted while busy and in DONE cycle → ignored; second start at T+33 produces second independent result.
- resetn low at T+10 for 1 cycle → busy=0, out_vec=0, dot_aclr=1; fresh start afterward yields correct result.
- Row-permutation matrix (row r selects lane 3−r) → out_vec lanes 40800000,40400000,40000000,3F800000, verifying tag-to-lane mapping.
